// File: rtl/jk_ms_bank_if.sv
// jk_ms_bank_if: control, data and status bundle for the jk_ms_bank flip-flop bank; JK_EVENT_CNT_EN adds ev_cnt/cnt_clr
interface jk_ms_bank_if #(parameter int WIDTH = 8, parameter int TERMS = 3);
  logic                   PRE;
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH*TERMS-1:0] J;
  logic [WIDTH*TERMS-1:0] K;
  logic [WIDTH-1:0]       Q;
  logic [WIDTH-1:0]       QBAR;
  logic [WIDTH-1:0]       chg;
`ifdef JK_EVENT_CNT_EN
  logic [15:0]            ev_cnt;
  logic                   cnt_clr;
  modport master (output PRE, en, mode, J, K, cnt_clr, input Q, QBAR, chg, ev_cnt);
  modport slave  (input PRE, en, mode, J, K, cnt_clr, output Q, QBAR, chg, ev_cnt);
`else
  modport master (output PRE, en, mode, J, K, input Q, QBAR, chg);
  modport slave  (input PRE, en, mode, J, K, output Q, QBAR, chg);
`endif
endinterface

// File: rtl/jk_ms_bank.sv
// jk_ms_bank: bank of WIDTH JK flip-flops with JK/D/T/hold modes, change mask, optional JK_EVENT_CNT_EN event counter
module jk_ms_bank #(
  parameter int WIDTH = 8,
  parameter int TERMS = 3
) (
  input logic          clk,
  input logic          CLR,
  jk_ms_bank_if.slave  bus
);
  logic [WIDTH-1:0] q, j, k, nxt, chg;
  for (genvar i = 0; i < WIDTH; i++) begin : g_and
    assign j[i] = &bus.J[i*TERMS +: TERMS];
    assign k[i] = &bus.K[i*TERMS +: TERMS];
  end
  assign nxt = bus.PRE            ? '1 :
               !bus.en            ? q :
               bus.mode == 2'b00  ? (j & ~q) | (~k & q) :
               bus.mode == 2'b01  ? j :
               bus.mode == 2'b10  ? q ^ j : q;
  always_ff @(posedge clk or posedge CLR)
    if (CLR) begin
      q   <= '0;
      chg <= '0;
    end else begin
      q   <= nxt;
      chg <= nxt ^ q;
    end
  assign bus.Q    = q;
  assign bus.QBAR = ~q;
  assign bus.chg  = chg;
`ifdef JK_EVENT_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge CLR)
    if (CLR) cnt <= '0;
    else if (bus.cnt_clr) cnt <= '0;
    else if (|(nxt ^ q) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign bus.ev_cnt = cnt;
`endif
endmodule

// File: tb/tb_jk_ms_bank.sv
// tb_jk_ms_bank: directed and random checks of jk_ms_bank against a per-bit reference model
module tb_jk_ms_bank;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0]  mq = '0;
  logic [7:0]  mchg = '0;
  logic [15:0] mcnt = '0;
  logic [7:0]  held;
  jk_ms_bank_if #(.WIDTH(8), .TERMS(3)) bus ();
  jk_ms_bank #(.WIDTH(8), .TERMS(3)) dut (.clk(clk), .CLR(clr), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] cur);
    logic [7:0] r;
    logic jj, kk;
    r = cur;
    if (bus.PRE) return 8'hFF;
    if (!bus.en) return cur;
    for (int b = 0; b < 8; b++) begin
      jj = 1'b1;
      kk = 1'b1;
      for (int t = 0; t < 3; t++) begin
        if (bus.J[b*3+t] !== 1'b1) jj = 1'b0;
        if (bus.K[b*3+t] !== 1'b1) kk = 1'b0;
      end
      case (bus.mode)
        2'd0: r[b] = (jj && kk) ? !cur[b] : jj ? 1'b1 : kk ? 1'b0 : cur[b];
        2'd1: r[b] = jj;
        2'd2: r[b] = jj ? !cur[b] : cur[b];
        default: r[b] = cur[b];
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    mq = '0;
    mchg = '0;
    mcnt = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, {8'h0, bus.Q}, {8'h0, mq});
    check({tag, ".qbar"}, {8'h0, bus.QBAR}, {8'h0, ~mq});
    check({tag, ".chg"}, {8'h0, bus.chg}, {8'h0, mchg});
`ifdef JK_EVENT_CNT_EN
    check({tag, ".cnt"}, bus.ev_cnt, mcnt);
`endif
  endtask

  task automatic step(input string tag);
    logic [7:0] n;
    n = ref_next(mq);
    @(posedge clk);
    #1;
    mchg = n ^ mq;
    mq = n;
`ifdef JK_EVENT_CNT_EN
    if (bus.cnt_clr) mcnt = '0;
    else if (mchg != 0 && mcnt != 16'hFFFF) mcnt++;
`endif
    check_all(tag);
  endtask

  // Slice generator: each bit's J (or K) group is all ones about half the time
  function automatic logic [23:0] rand_terms();
    logic [23:0] v;
    v = 24'($urandom);
    for (int b = 0; b < 8; b++)
      if ($urandom_range(1, 0) == 1) v[b*3 +: 3] = 3'b111;
    return v;
  endfunction

  initial begin
    bus.PRE = 1'b0;
    bus.en = 1'b0;
    bus.mode = 2'b11;
    bus.J = '0;
    bus.K = '0;
`ifdef JK_EVENT_CNT_EN
    bus.cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check_all("reset");
    // Preset with enable low, then an async clear with no clock edge
    bus.PRE = 1'b1;
    step("pre_en0");
    check("pre_en0.const", {8'h0, bus.Q}, 16'h00FF);
    bus.PRE = 1'b0;
    #1 clr = 1'b1;
    #1;
    model_reset();
    check("async_clr.q", {8'h0, bus.Q}, 16'h0000);
    check("async_clr.qbar", {8'h0, bus.QBAR}, 16'h00FF);
    check("async_clr.chg", {8'h0, bus.chg}, 16'h0000);
    #1 clr = 1'b0;
    // JK truth table: bit0 set, bit1 set then reset, bit2 toggle, bit3 partial J
    bus.en = 1'b1;
    bus.mode = 2'b00;
    bus.J = 24'b000_011_111_111_111;
    bus.K = 24'b000_000_111_000_000;
    step("jk1");
    check("jk1.const", {8'h0, bus.Q}, 16'h0007);
    bus.J = 24'b000_011_111_000_111;
    bus.K = 24'b000_000_111_111_000;
    step("jk2");
    check("jk2.const", {8'h0, bus.Q}, 16'h0001);
    step("jk3");
    check("jk3.const", {8'h0, bus.Q}, 16'h0005);
    step("jk4");
    check("jk4.const", {8'h0, bus.Q}, 16'h0001);
    // T mode from zero with every J group high
    clr = 1'b1;
    #1 model_reset();
    clr = 1'b0;
    bus.mode = 2'b10;
    bus.J = '1;
    bus.K = '0;
    step("t1");
    check("t1.const", {bus.chg, bus.Q}, 16'hFFFF);
    step("t2");
    check("t2.const", {bus.chg, bus.Q}, 16'hFF00);
    step("t3");
    check("t3.const", {bus.chg, bus.Q}, 16'hFFFF);
    // Hold via mode 11 then via en low
    bus.J = 24'hA5A5A5;
    bus.K = 24'h5A5A5A;
    bus.mode = 2'b11;
    held = mq;
    for (int n = 0; n < 5; n++) step("hold_mode");
    check("hold_mode.const", {bus.chg, bus.Q}, {8'h00, held});
    bus.mode = 2'b00;
    bus.en = 1'b0;
    for (int n = 0; n < 5; n++) step("hold_en");
    check("hold_en.const", {bus.chg, bus.Q}, {8'h00, held});
    // PRE together with CLR: clear dominates across an edge
    bus.PRE = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("pre_clr.q", {8'h0, bus.Q}, 16'h0000);
    check_all("pre_clr");
    @(negedge clk);
    clr = 1'b0;
    step("pre_after_clr");
    check("pre_after_clr.const", {bus.chg, bus.Q}, 16'hFFFF);
    bus.PRE = 1'b0;
    // Random traffic with occasional preset, counter clear and async clear pulses
    for (int n = 0; n < 400; n++) begin
      bus.PRE = ($urandom_range(15, 0) == 0);
      bus.en = ($urandom_range(3, 0) != 0);
      bus.mode = 2'($urandom);
      bus.J = rand_terms();
      bus.K = rand_terms();
`ifdef JK_EVENT_CNT_EN
      bus.cnt_clr = ($urandom_range(31, 0) == 0);
`endif
      if ($urandom_range(31, 0) == 0) begin
        clr = 1'b1;
        #1 model_reset();
        check_all("rand_clr");
        clr = 1'b0;
      end
      step("rand");
    end
`ifdef JK_EVENT_CNT_EN
    // Counter saturation: toggle every edge until one below the limit
    bus.cnt_clr = 1'b0;
    bus.PRE = 1'b0;
    bus.en = 1'b1;
    bus.mode = 2'b10;
    bus.J = '1;
    while (mcnt != 16'hFFFE) step("cnt_ramp");
    for (int n = 0; n < 3; n++) step("cnt_sat");
    check("cnt_sat.const", bus.ev_cnt, 16'hFFFF);
    bus.cnt_clr = 1'b1;
    step("cnt_clr");
    check("cnt_clr.const", bus.ev_cnt, 16'h0000);
    bus.cnt_clr = 1'b0;
    step("cnt_after_clr");
    check("cnt_after_clr.const", bus.ev_cnt, 16'h0001);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
